// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for the 4-bit up/down/load counter: load lo, count to hi,
// back to lo, N passes, while a shadow position cross-checks the returned count.
module counter_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [PW-1:0]    passes,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_in,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             mis_err,
  output logic [PW-1:0]    pass_idx
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [PW-1:0]    ONE_P  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ZERO_P = {PW{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pos_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [PW-1:0]    passes_r;
  logic [PW-1:0]    pass_idx_r;
  logic             cfg_err_r;
  logic             mis_err_r;

  logic             cfg_ok_s;
  logic             accept_s;
  logic [WIDTH-1:0] pos_inc_s;
  logic [WIDTH-1:0] pos_dec_s;
  logic [PW-1:0]    pass_nxt_s;

  // A run is legal only if it sweeps at least one step and at least once.
  assign cfg_ok_s   = (hi > lo) && (passes != ZERO_P);
  assign accept_s   = (state_r == S_IDLE) && start && !abort && cfg_ok_s;
  assign pos_inc_s  = pos_r + ONE_W;
  assign pos_dec_s  = pos_r - ONE_W;
  assign pass_nxt_s = pass_idx_r + ONE_P;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort outranks hold and every sweep turn.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_LOAD;
        else          state_s = S_IDLE;
      end
      S_LOAD: begin
        if (abort) state_s = S_IDLE;
        else       state_s = S_UP;
      end
      S_UP: begin
        if (abort)                           state_s = S_IDLE;
        else if (!hold && pos_inc_s == hi_r) state_s = S_DOWN;
        else                                 state_s = S_UP;
      end
      S_DOWN: begin
        if (abort)                           state_s = S_IDLE;
        else if (!hold && pos_dec_s == lo_r) state_s = (pass_nxt_s == passes_r) ? S_DONE : S_UP;
        else                                 state_s = S_DOWN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Shadow position, latched run parameters, pass count and error flags.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pos_r      <= ZERO_W;
      lo_r       <= ZERO_W;
      hi_r       <= ZERO_W;
      passes_r   <= ZERO_P;
      pass_idx_r <= ZERO_P;
      cfg_err_r  <= 1'b0;
      mis_err_r  <= 1'b0;
    end else begin
      cfg_err_r <= (state_r == S_IDLE) && start && !abort && !cfg_ok_s;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            lo_r       <= lo;
            hi_r       <= hi;
            passes_r   <= passes;
            pass_idx_r <= ZERO_P;
            mis_err_r  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!abort) pos_r <= lo_r;
        end
        S_UP: begin
          if (cnt_out != pos_r) mis_err_r <= 1'b1;
          if (!abort && !hold)  pos_r <= pos_inc_s;
        end
        S_DOWN: begin
          if (cnt_out != pos_r) mis_err_r <= 1'b1;
          if (!abort && !hold) begin
            pos_r <= pos_dec_s;
            if (pos_dec_s == lo_r) pass_idx_r <= pass_nxt_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore decode of the counter controls; only cnt_en sees hold directly.
  always_comb begin
    cnt_en   = 1'b0;
    cnt_dir  = 1'b1;
    cnt_in   = 1'b0;
    cnt_data = ZERO_W;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_r)
      S_LOAD: begin
        cnt_en   = 1'b1;
        cnt_in   = 1'b1;
        cnt_data = lo_r;
        busy     = 1'b1;
      end
      S_UP: begin
        cnt_en = !hold;
        busy   = 1'b1;
      end
      S_DOWN: begin
        cnt_en  = !hold;
        cnt_dir = 1'b0;
        busy    = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        cnt_en = 1'b0;
      end
    endcase
  end

  assign cfg_err  = cfg_err_r;
  assign mis_err  = mis_err_r;
  assign pass_idx = pass_idx_r;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural 4-bit counter closes the loop and the
// expected triangle path is built from lo/hi/passes as a plain list of positions.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, hold;
  logic [3:0] lo, hi, passes;
  logic [3:0] cnt_out;
  logic       cnt_en, cnt_dir, cnt_in;
  logic [3:0] cnt_data;
  logic       busy, done, cfg_err, mis_err;
  logic [3:0] pass_idx;

  logic [3:0] cnt_q;
  logic       force_en;
  logic [3:0] force_val;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] passes;
    int         mode;    // 0 plain, 1 random hold, 2 hold 3 at up-leg 5, 3 force 9 at 5, 4 abort at down-leg 4, 5 abort with start in IDLE
    bit         accept;
    int         lat;     // expected start-to-done cycles, -1 = derive from path and holds
  } vec_t;

  vec_t tbl[12];

  counter_sweep_ctrl #(.WIDTH(4), .PW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .lo(lo), .hi(hi), .passes(passes), .cnt_out(cnt_out),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_in(cnt_in), .cnt_data(cnt_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .mis_err(mis_err), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  // Behavioural up/down/load counter sharing the controller's reset.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n)       cnt_q <= 4'd0;
    else if (cnt_en) cnt_q <= cnt_in ? cnt_data : (cnt_dir ? cnt_q + 4'd1 : cnt_q - 4'd1);
  end

  assign cnt_out = force_en ? force_val : cnt_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic do_reject(input logic [3:0] l, input logic [3:0] h, input logic [3:0] p, input bit with_abort);
    start = 1'b1; abort = with_abort; lo = l; hi = h; passes = p;
    #1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    chk("rej_cfg_err", cfg_err, !with_abort);
    chk("rej_busy", busy, 1'b0);
    chk("rej_en", cnt_en, 1'b0);
    @(posedge clk); #2;
    chk("rej_cfg_err_pulse", cfg_err, 1'b0);
    chk("rej_busy2", busy, 1'b0);
  endtask

  task automatic do_run(input logic [3:0] l, input logic [3:0] h, input logic [3:0] p,
                        input int mode, input int exp_lat);
    int path[$];
    int d, idx, cyc, last, hold_left, holds;
    bit hold_used, force_used, mis_seen, h_v, up, lh;
    d = int'(h) - int'(l);
    path.push_back(int'(l));
    for (int k = 0; k < int'(p); k++) begin
      for (int s = 1; s <= d; s++)      path.push_back(int'(l) + s);
      for (int s = d - 1; s >= 0; s--)  path.push_back(int'(l) + s);
    end
    last = path.size() - 1;
    idx = 0; hold_left = 0; holds = 0;
    hold_used = 1'b0; force_used = 1'b0; mis_seen = 1'b0;

    start = 1'b1; lo = l; hi = h; passes = p; hold = 1'b0;
    #1;
    chk("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    lh = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    start = 1'b0; hold = lh;
    lo = 4'($urandom); hi = 4'($urandom); passes = 4'($urandom);
    #1;
    chk("load_ctl", {cnt_en, cnt_in, busy, mis_err}, 4'b1110);
    chk("load_data", cnt_data, l);
    cyc = 1;

    for (int g = 0; g < 2000; g++) begin
      @(posedge clk); #1;
      cyc++;
      force_en = 1'b0; abort = 1'b0;
      if (idx < last) begin
        up  = path[idx+1] > path[idx];
        h_v = 1'b0;
        if (mode == 1) h_v = ($urandom_range(0, 3) == 0);
        if (mode == 2 && !hold_used && up && path[idx] == 5) begin
          hold_left = 3; hold_used = 1'b1;
        end
        if (hold_left > 0) begin
          h_v = 1'b1; hold_left--;
        end
        hold = h_v;
        start = 1'($urandom_range(0, 1));
        lo = 4'($urandom); hi = 4'($urandom); passes = 4'($urandom);
        if (mode == 3 && !force_used && path[idx] == 5) begin
          force_en = 1'b1; force_val = 4'd9; force_used = 1'b1;
        end
        if (mode == 4 && !up && path[idx] == 4) abort = 1'b1;
        #1;
        if (!force_en) chk("cnt_out", cnt_out, path[idx]);
        chk("cnt_en", cnt_en, !h_v);
        chk("cnt_dir", cnt_dir, up);
        chk("cnt_in", cnt_in, 1'b0);
        chk("busy", busy, 1'b1);
        chk("no_done", done, 1'b0);
        chk("pass_idx", pass_idx, idx / (2 * d));
        chk("mis_err", mis_err, mis_seen);
        if (force_en) mis_seen = 1'b1;
        if (!h_v) idx++;
        holds += int'(h_v);
        if (abort) begin
          @(posedge clk); #1;
          abort = 1'b0; start = 1'b0; hold = 1'b0;
          #1;
          chk("abort_busy", busy, 1'b0);
          chk("abort_en", cnt_en, 1'b0);
          chk("abort_done", done, 1'b0);
          chk("abort_cnt", cnt_out, path[idx]);
          for (int w = 0; w < 2; w++) begin
            @(posedge clk); #2;
            chk("abort_frozen", cnt_out, path[idx]);
            chk("abort_no_done", done, 1'b0);
          end
          return;
        end
      end else begin
        hold = 1'b0; start = 1'b0;
        #1;
        chk("done", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_en", cnt_en, 1'b0);
        chk("done_cnt", cnt_out, l);
        chk("done_pass_idx", pass_idx, p);
        chk("done_mis", mis_err, mis_seen);
        chk("latency", cyc, (exp_lat < 0) ? 2 + last + holds : exp_lat);
        @(posedge clk); #2;
        chk("done_pulse", done, 1'b0);
        chk("final_pass_idx", pass_idx, p);
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    tbl[0]  = '{4'd3,  4'd6,  4'd2, 0, 1'b1, 14};
    tbl[1]  = '{4'd3,  4'd6,  4'd2, 2, 1'b1, 17};
    tbl[2]  = '{4'd7,  4'd7,  4'd1, 0, 1'b0, 0};
    tbl[3]  = '{4'd5,  4'd9,  4'd0, 0, 1'b0, 0};
    tbl[4]  = '{4'd0,  4'd15, 4'd1, 0, 1'b1, 32};
    tbl[5]  = '{4'd3,  4'd6,  4'd1, 4, 1'b1, 0};
    tbl[6]  = '{4'd3,  4'd6,  4'd2, 3, 1'b1, 14};
    tbl[7]  = '{4'd3,  4'd6,  4'd1, 0, 1'b1, 8};
    tbl[8]  = '{4'd9,  4'd3,  4'd2, 0, 1'b0, 0};
    tbl[9]  = '{4'd14, 4'd15, 4'd3, 1, 1'b1, -1};
    tbl[10] = '{4'd1,  4'd2,  4'd1, 0, 1'b1, 4};
    tbl[11] = '{4'd2,  4'd5,  4'd1, 5, 1'b0, 0};

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    lo = 4'd0; hi = 4'd0; passes = 4'd0; force_en = 1'b0; force_val = 4'd0;
    #3;
    chk("rst_ctl", {cnt_en, cnt_dir, cnt_in, busy, done, cfg_err, mis_err}, 7'b0100000);
    chk("rst_data", cnt_data, 4'd0);
    chk("rst_pass_idx", pass_idx, 4'd0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (!tbl[i].accept) do_reject(tbl[i].lo, tbl[i].hi, tbl[i].passes, tbl[i].mode == 5);
      else                do_run(tbl[i].lo, tbl[i].hi, tbl[i].passes, tbl[i].mode, tbl[i].lat);
    end

    // Reset in the middle of the second pass of a 2..4 x3 run.
    start = 1'b1; lo = 4'd2; hi = 4'd4; passes = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_pass_idx", pass_idx, 4'd1);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b1;
    #1;
    chk("async_rst_ctl", {cnt_en, cnt_dir, cnt_in, busy, done, cfg_err, mis_err}, 7'b0100000);
    chk("async_rst_pass_idx", pass_idx, 4'd0);
    chk("async_rst_cnt", cnt_out, 4'd0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    do_run(4'd3, 4'd6, 4'd2, 0, 14);

    // Randomized runs with random hold, plus occasional illegal configurations.
    for (int r = 0; r < 20; r++) begin
      logic [3:0] rl, rh, rp;
      if ($urandom_range(0, 4) == 0) begin
        rl = 4'($urandom);
        rh = 4'($urandom_range(0, int'(rl)));
        rp = 4'($urandom);
        do_reject(rl, rh, rp, 1'b0);
      end else begin
        rl = 4'($urandom_range(0, 14));
        rh = 4'($urandom_range(int'(rl) + 1, 15));
        rp = 4'($urandom_range(1, 3));
        do_run(rl, rh, rp, 1, -1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer that drives the control inputs of the team's 4-bit up/down counter with load (en/dir/in/data) so the counter performs programmed triangle sweeps.
- Each sweep loads `lo`, counts up to `hi`, then counts back down to `lo`; this repeats for N passes.
- An internal shadow position tracks the counter; the returned counter value is checked against it every cycle, and any divergence sets a sticky error flag.
- The block sits between a host or test FSM and the counter instance.

Parameters:
WIDTH, 4, width of counter value, `lo`/`hi`, `cnt_data` and `cnt_out`
PW, 4, width of the pass-count input and pass index

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
start  in  1  request a sweep run; sampled in IDLE only
abort  in  1  terminate the run; return to IDLE
hold  in  1  freeze counting in UP/DOWN (cnt_en=0, state kept)
lo  in  WIDTH  sweep low bound; latched on accepted start
hi  in  WIDTH  sweep high bound; latched on accepted start
passes  in  PW  number of lo->hi->lo passes; latched on accepted start
cnt_out  in  WIDTH  counter output fed back
cnt_en  out  1  counter enable
cnt_dir  out  1  counter direction, 1=up, 0=down
cnt_in  out  1  counter load strobe
cnt_data  out  WIDTH  counter load value
busy  out  1  high in LOAD/UP/DOWN
done  out  1  one-cycle pulse (state DONE)
cfg_err  out  1  one-cycle pulse: start rejected
mis_err  out  1  sticky: cnt_out != shadow position
pass_idx  out  PW  number of passes completed in current run

Behaviour:
- Counter outputs are Moore, decoded from state and registers only; no combinational path from inputs except `cnt_en` gating by `hold`.
- Reset values:
  - state=IDLE; pos=0; lo_r/hi_r/passes_r=0; pass_idx=0.
  - cnt_en=0, cnt_dir=1, cnt_in=0, cnt_data=0.
  - busy=0, done=0, cfg_err=0, mis_err=0.
- IDLE: cnt_en=0, cnt_in=0, cnt_dir=1, cnt_data=0.
  - start=1 with hi>lo and passes!=0: latch lo/hi/passes; pass_idx<=0; mis_err<=0; go to LOAD.
  - start=1 otherwise: stay in IDLE; cfg_err=1 for the following cycle only.
- LOAD (exactly 1 cycle): cnt_en=1, cnt_in=1, cnt_data=lo_r. At the edge pos<=lo_r; go to UP. `hold` is ignored in LOAD.
- UP: cnt_en=~hold, cnt_dir=1, cnt_in=0.
  - Each edge with hold=0: pos<=pos+1.
  - If pos+1==hi_r on that edge, go to DOWN.
- DOWN: cnt_en=~hold, cnt_dir=0, cnt_in=0.
  - Each edge with hold=0: pos<=pos-1.
  - If pos-1==lo_r on that edge: pass_idx<=pass_idx+1; go to DONE if pass_idx+1==passes_r, else to UP.
- DONE (1 cycle): cnt_en=0; done=1; go to IDLE. pass_idx holds its final value until the next accepted start.
- Arithmetic:
  - pos stays within [lo_r, hi_r], so no wrap is ever commanded.
  - The counter's own 15->0 and 0->15 wrap must never be exercised.
- Latency with no hold: start accepted at edge 0; LOAD occupies cycle 1; cycles in UP/DOWN = 2*(hi-lo)*passes; done asserts in the following cycle. Total = 2 + 2*(hi-lo)*passes cycles from start acceptance.
- Mismatch check: in UP and DOWN every cycle, cnt_out!=pos sets mis_err=1 at the next edge. mis_err is cleared only by reset or an accepted start. A mismatch does not stop the sweep.
- abort=1 in LOAD/UP/DOWN/DONE: go to IDLE at the next edge, with IDLE outputs from then on; done is not pulsed.
  - abort has priority over hold and over the sweep transitions.
  - abort in IDLE has priority over start: the start is not accepted.
- start while busy is ignored; latched parameters never change mid-run.
- Reset asserted mid-run: immediate asynchronous return to reset values. Counter-side consistency is the integrator's job: the counter shares the same reset.

Test Plan:
1. lo=3, hi=6, passes=2, hold=0:
   - cnt_out after LOAD = 3,4,5,6,5,4,3,4,5,6,5,4,3.
   - done pulses 14 cycles after start; pass_idx=2; mis_err=0.
2. Same run with hold=1 for 3 cycles while cnt_out=5 on the up leg: cnt_en=0 and cnt_out stays 5 for 3 cycles, then the sequence resumes; done arrives 3 cycles late.
3. Config rejection:
   - lo=7, hi=7 -> cfg_err single pulse, busy=0, cnt_en=0.
   - passes=0 -> same response.
   - lo=0, hi=15, passes=1 -> full 0..15..0 sweep, done after 32 cycles.
4. abort asserted when cnt_out=4 on the down leg: next cycle state is IDLE, cnt_en=0, cnt_out frozen at 3, no done pulse; a new start is accepted afterwards.
5. Force cnt_out to 9 while pos=5 for 1 cycle: mis_err=1 from the next edge and stays 1 through done; it clears on the next accepted start.
6. rst_n=1 pulsed mid-sweep: all outputs take reset values immediately without waiting for clk; busy=0, pass_idx=0; after release, a start runs normally.
